// File: rtl/core_sequencer.sv
// ---------------------------------------------------------------------------
// core_sequencer
//
// Multi-cycle control FSM wrapped around a combinational execute unit.
// Each instruction takes a FETCH phase (req/valid handshake with instruction
// memory) followed by exactly one EXEC cycle in which the execute unit's
// outputs are sampled. The block owns the PC, the latched instruction, a
// saturating retired-instruction counter and a sticky error flag. It halts
// on an execute error, a misaligned next PC, a zero instruction (a clean
// stop) or a fetch timeout. HALT is left only through rst.
//
// Ports
//   clk            clock, all state changes on the rising edge
//   rst            synchronous active-high reset
//   start          leaves IDLE; ignored elsewhere
//   imem_req       fetch request, high throughout FETCH
//   imem_addr      fetch address (always equal to pc)
//   imem_valid     fetch data valid, looked at only in FETCH
//   imem_rdata     fetched instruction word
//   instr          latched instruction driven to decode/execute
//   exe_sonuc      execute result / branch offset
//   exe_pc_update  branch taken
//   exe_we         register write request
//   exe_hata       execute error
//   rf_we          gated register-file write enable (EXEC only)
//   pc             program counter
//   busy           high in FETCH or EXEC
//   halted         high in HALT
//   hata           sticky error flag
//   retired        completed-instruction count, saturating
// ---------------------------------------------------------------------------
module core_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    input  logic [31:0] exe_sonuc,
    input  logic        exe_pc_update,
    input  logic        exe_we,
    input  logic        exe_hata,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic        busy,
    output logic        halted,
    output logic        hata,
    output logic [31:0] retired
);

    // The wait counter only has to hold FETCH_TIMEOUT-1: the cycle that
    // would reach FETCH_TIMEOUT is the one that decides the timeout.
    localparam int            CW       = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT);
    localparam logic [CW-1:0] TMO_LAST = CW'(FETCH_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t        state_reg,   state_next;
    logic [31:0]   pc_reg,      pc_next;
    logic [31:0]   instr_reg,   instr_next;
    logic [31:0]   retired_reg, retired_next;
    logic          hata_reg,    hata_next;
    logic [CW-1:0] tmo_cnt_reg, tmo_cnt_next;

    logic [31:0]   branch_pc;
    logic          instr_nonzero;

    assign instr_nonzero = (instr_reg != 32'h0);
    // Silent modulo-2^32 wrap is intended for both sequential and branch PCs.
    assign branch_pc     = exe_pc_update ? (pc_reg + exe_sonuc) : (pc_reg + 32'd4);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            pc_reg      <= RESET_PC;
            instr_reg   <= 32'h0;
            retired_reg <= 32'h0;
            hata_reg    <= 1'b0;
            tmo_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            instr_reg   <= instr_next;
            retired_reg <= retired_next;
            hata_reg    <= hata_next;
            tmo_cnt_reg <= tmo_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        instr_next   = instr_reg;
        retired_next = retired_reg;
        hata_next    = hata_reg;
        tmo_cnt_next = tmo_cnt_reg;

        unique case (state_reg)
            ST_IDLE: begin
                pc_next      = RESET_PC;
                tmo_cnt_next = '0;
                if (start) begin
                    state_next = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (imem_valid) begin
                    // A valid on the last allowed cycle still wins.
                    instr_next   = imem_rdata;
                    tmo_cnt_next = '0;
                    state_next   = ST_EXEC;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    tmo_cnt_next = '0;
                    hata_next    = 1'b1;
                    state_next   = ST_HALT;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end

            ST_EXEC: begin
                if (!instr_nonzero) begin
                    state_next = ST_HALT;             // clean stop, no error
                end else if (exe_hata) begin
                    hata_next  = 1'b1;
                    state_next = ST_HALT;
                end else if (branch_pc[1:0] != 2'b00) begin
                    hata_next  = 1'b1;
                    state_next = ST_HALT;
                end else begin
                    pc_next      = branch_pc;
                    retired_next = (retired_reg == 32'hFFFF_FFFF) ? retired_reg
                                                                  : retired_reg + 32'd1;
                    state_next   = ST_FETCH;
                end
            end

            ST_HALT: begin
                state_next = ST_HALT;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Write enable is not suppressed by a misaligned target: the target
    // check only affects PC/retire/halt, not the register write.
    assign rf_we     = (state_reg == ST_EXEC) & exe_we & ~exe_hata & instr_nonzero;
    assign imem_req  = (state_reg == ST_FETCH);
    assign imem_addr = pc_reg;
    assign instr     = instr_reg;
    assign pc        = pc_reg;
    assign busy      = (state_reg == ST_FETCH) | (state_reg == ST_EXEC);
    assign halted    = (state_reg == ST_HALT);
    assign hata      = hata_reg;
    assign retired   = retired_reg;

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control FSM that sequences the processor around the combinational execute unit.
- Fetches each instruction from instruction memory over a req/valid handshake.
- Latches the instruction for decode, then samples the execute unit's pc_update/we/hata/sonuc outputs.
- Gates the register-file write enable, owns the PC register and a retired-instruction counter.
- Halts on error, on a zero instruction or on fetch timeout.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset and in IDLE.
FETCH_TIMEOUT, 16, maximum consecutive FETCH cycles without imem_valid before an error halt (>=1).

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst  in  1  synchronous reset, active-high.
start  in  1  leaves IDLE when high in IDLE; ignored in other states.
imem_req  out  1  fetch request; high throughout FETCH.
imem_addr  out  32  fetch address; equals pc.
imem_valid  in  1  instruction-memory data valid; sampled only in FETCH.
imem_rdata  in  32  fetched instruction word.
instr  out  32  latched instruction, driven to decode/execute.
exe_sonuc  in  32  execute result; branch offset when exe_pc_update=1.
exe_pc_update  in  1  branch taken.
exe_we  in  1  register write request.
exe_hata  in  1  execute error (illegal opcode/func).
rf_we  out  1  register-file write enable.
pc  out  32  program counter.
busy  out  1  high in FETCH or EXEC.
halted  out  1  high in HALT.
hata  out  1  sticky error flag.
retired  out  32  count of completed instructions; saturates at 32'hFFFF_FFFF.

Behaviour:
- Reset values:
  - State IDLE; pc=RESET_PC; instr=0; retired=0; hata=0; timeout counter=0.
  - imem_req, rf_we, busy and halted all 0.
- rst takes priority in every state, including mid-FETCH and mid-EXEC. Next cycle the block is in reset condition and imem_req=0.
- IDLE:
  - pc held at RESET_PC; outputs inactive.
  - start=1 -> FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc; timeout counter increments each cycle.
  - imem_valid=1: instr<=imem_rdata, counter cleared, go to EXEC. No fetch wait states are added.
  - Timeout: after FETCH_TIMEOUT consecutive cycles without imem_valid, the next state is HALT with hata<=1.
  - imem_valid=1 on the FETCH_TIMEOUT-th cycle counts as a successful fetch.
- EXEC (exactly one cycle):
  - The execute unit settles combinationally from instr; exe_* inputs are sampled at the end of the cycle.
  - rf_we = exe_we & ~exe_hata & (instr!=0), combinational, high only during EXEC.
  - Priority at end of EXEC:
    1. instr==32'h0: clean stop, go to HALT, hata unchanged, pc unchanged, retired unchanged.
    2. exe_hata=1: go to HALT, hata<=1, pc unchanged, retired unchanged.
    3. Compute next_pc = exe_pc_update ? pc+exe_sonuc : pc+4, modulo 2^32 with silent wrap.
    4. next_pc[1:0]!=0: go to HALT, hata<=1, pc unchanged, retired unchanged. rf_we is still asserted this cycle per the rule above.
    5. Otherwise: pc<=next_pc, retired<=retired+1 (saturating), go to FETCH.
- Latency: one instruction per 2 cycles minimum (FETCH with immediate valid + EXEC).
- HALT:
  - halted=1; all other outputs held; imem_req=0, rf_we=0.
  - start ignored; exit only via rst.
- exe_* inputs are don't-care outside EXEC; imem_valid/imem_rdata are don't-care outside FETCH.

Test Plan:
1. Basic ADD:
   - Stimulus: rst, start; imem_valid=1 on the first FETCH cycle with a nonzero instr; in EXEC exe_we=1, exe_pc_update=0, exe_hata=0.
   - Required: rf_we high for exactly 1 cycle; pc 0->4; retired=1; back in FETCH.
2. Taken branch:
   - Stimulus: at pc=8, exe_pc_update=1, exe_sonuc=32'h10, exe_we=0.
   - Required: pc=32'h18; rf_we=0; retired increments.
   - Variant: exe_sonuc=32'hFFFF_FFF8 at pc=8 -> pc=0.
3. Misaligned target:
   - Stimulus: at pc=4, exe_pc_update=1, exe_sonuc=6.
   - Required: HALT, hata=1, halted=1, pc stays 4, retired unchanged.
4. Execute error and clean stop:
   - Stimulus A: exe_hata=1 with exe_we=1.
   - Required A: rf_we=0; HALT; hata=1.
   - Stimulus B: in a separate run, instr=0.
   - Required B: HALT with hata=0.
5. Fetch timeout:
   - Stimulus A: imem_valid=0 for 16 FETCH cycles.
   - Required A: HALT with hata=1 on the 17th cycle.
   - Stimulus B: valid on exactly the 16th cycle.
   - Required B: proceeds to EXEC normally.
6. Reset mid-operation:
   - Stimulus: assert rst during FETCH (pc=32'h20) and, separately, during EXEC.
   - Required: next cycle IDLE, pc=RESET_PC, imem_req=0, rf_we=0, retired=0, hata=0.
   - Required: start in HALT has no effect.
